// File: rtl/msbus_arbiter.sv
// Round-robin arbiter that shares one msbus master port among NREQ requesters, one transaction per grant.
// Optional s_vld timeout abort is built when MSBUS_ARB_TIMEOUT_EN is defined; otherwise waits are unbounded.

module msbus_arbiter #(
    parameter int NREQ  = 4,
    parameter int TMO_W = 8,
    parameter int TMO   = 200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [32*NREQ-1:0]   req_addr,
    input  logic [32*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [31:0]          rdata,
    output logic                 err,
    output logic                 m_ce,
    output logic                 m_wr,
    output logic [31:0]          m_addr_wdata,
    input  logic [31:0]          s_rdata,
    input  logic                 s_vld
);

    localparam int IDX_W = $clog2(NREQ);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDAT,
        ST_RWAIT,
        ST_DONE
    } state_t;

    if (NREQ < 2 || NREQ > 8 || TMO < 2 || TMO > (1 << TMO_W)) begin : g_param_err
        $error("msbus_arbiter: illegal parameter set");
    end

    state_t           state_q;
    logic [IDX_W-1:0] ptr_q;
    logic             wr_q;
    logic [31:0]      wdata_q;
    logic [NREQ-1:0]  gnt_q;
    logic [NREQ-1:0]  done_q;
    logic [31:0]      rdata_q;
    logic             m_ce_q;
    logic             m_wr_q;
    logic [31:0]      m_bus_q;
`ifdef MSBUS_ARB_TIMEOUT_EN
    logic             err_q;
    logic [TMO_W-1:0] tmo_q;
`endif

    // Winner search: first set request scanning upward from ptr_q, wrapping at NREQ.
    logic [IDX_W:0]   arb_sum;
    logic [IDX_W-1:0] owner_d;
    logic [IDX_W-1:0] ptr_d;
    logic             arb_hit;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        arb_hit = 1'b0;
        owner_d = '0;
        arb_sum = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            arb_sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (arb_sum >= (IDX_W+1)'(NREQ)) begin
                arb_sum = arb_sum - (IDX_W+1)'(NREQ);
            end
            if (req[arb_sum[IDX_W-1:0]]) begin
                arb_hit = 1'b1;
                owner_d = arb_sum[IDX_W-1:0];
            end
        end
        ptr_d = (owner_d == IDX_W'(NREQ - 1)) ? '0 : owner_d + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            wr_q    <= 1'b1;
            wdata_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            m_ce_q  <= 1'b0;
            m_wr_q  <= 1'b1;
            m_bus_q <= '0;
`ifdef MSBUS_ARB_TIMEOUT_EN
            err_q   <= 1'b0;
            tmo_q   <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every register sees pre-edge values; state and outputs move together.
            done_q <= '0;
`ifdef MSBUS_ARB_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            unique case (state_q)
                ST_IDLE: begin
                    if (arb_hit) begin
                        ptr_q   <= ptr_d;
                        wr_q    <= req_wr[owner_d];
                        wdata_q <= req_wdata[{owner_d, 5'b0} +: 32];
                        gnt_q   <= {{(NREQ-1){1'b0}}, 1'b1} << owner_d;
                        m_ce_q  <= 1'b1;
                        m_wr_q  <= req_wr[owner_d];
                        m_bus_q <= req_addr[{owner_d, 5'b0} +: 32];
                        state_q <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    m_ce_q <= 1'b0;
`ifdef MSBUS_ARB_TIMEOUT_EN
                    tmo_q  <= '0;
`endif
                    if (wr_q) begin
                        m_wr_q  <= 1'b1;
                        m_bus_q <= wdata_q;
                        state_q <= ST_WDAT;
                    end else begin
                        m_wr_q  <= 1'b0;
                        m_bus_q <= '0;
                        state_q <= ST_RWAIT;
                    end
                end
                ST_WDAT, ST_RWAIT: begin
                    // s_vld on the expiry cycle still counts as a normal completion.
                    if (s_vld) begin
                        if (!wr_q) begin
                            rdata_q <= s_rdata;
                        end
                        done_q  <= gnt_q;
                        m_wr_q  <= 1'b1;
                        m_bus_q <= '0;
                        state_q <= ST_DONE;
                    end
`ifdef MSBUS_ARB_TIMEOUT_EN
                    else if (tmo_q == TMO_W'(TMO - 1)) begin
                        if (!wr_q) begin
                            rdata_q <= '0;
                        end
                        err_q   <= 1'b1;
                        done_q  <= gnt_q;
                        m_wr_q  <= 1'b1;
                        m_bus_q <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
`endif
                end
                ST_DONE: begin
                    gnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt          = gnt_q;
    assign done         = done_q;
    assign rdata        = rdata_q;
    assign m_ce         = m_ce_q;
    assign m_wr         = m_wr_q;
    assign m_addr_wdata = m_bus_q;
`ifdef MSBUS_ARB_TIMEOUT_EN
    assign err          = err_q;
`else
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_msbus_arbiter.sv
// Scoreboard bench for msbus_arbiter: expected transactions are queued at issue and checked at CMD, wait and done.
// A small slave model answers each command after a programmable number of wait cycles.

module tb_msbus_arbiter;

    localparam int NREQ = 4;

    typedef struct {
        int          owner;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
        int          lat;
        int          gap;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     req_wr;
    logic [32*NREQ-1:0]  req_addr;
    logic [32*NREQ-1:0]  req_wdata;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic [31:0]         rdata;
    logic                err;
    logic                m_ce;
    logic                m_wr;
    logic [31:0]         m_addr_wdata;
    logic [31:0]         s_rdata = 32'h0;
    logic                s_vld = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    exp_t sb[$];

    bit          slv_active   = 1'b0;
    bit          slv_spurious = 1'b0;
    int          slv_cnt      = 0;
    int          slv_delay    = 0;
    logic [31:0] slv_addr     = 32'h0;
    logic [31:0] slv_xor      = 32'h0;

    exp_t        cur;
    bit          in_wait       = 1'b0;
    bit          have_done     = 1'b0;
    int          cmd_cyc       = 0;
    int          last_done_cyc = 0;
    logic [31:0] mdl_rdata     = 32'h0;

    msbus_arbiter #(.NREQ(NREQ), .TMO_W(8), .TMO(200)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .gnt          (gnt),
        .done         (done),
        .rdata        (rdata),
        .err          (err),
        .m_ce         (m_ce),
        .m_wr         (m_wr),
        .m_addr_wdata (m_addr_wdata),
        .s_rdata      (s_rdata),
        .s_vld        (s_vld)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input int o, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rd, input bit e, input int lat);
        exp_t x;
        x.owner = o; x.wr = wr; x.addr = addr; x.wdata = wdata;
        x.rdata = rd; x.err = e; x.lat = lat; x.gap = 0;
        req_wr[o]              = wr;
        req_addr[32*o +: 32]   = addr;
        req_wdata[32*o +: 32]  = wdata;
        sb.push_back(x);
        req[o] = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    // Slave: answers s_vld a programmable number of wait cycles after the command cycle.
    always @(negedge clk) begin
        if (!rst) slv_active = 1'b0;
        s_vld   = 1'b0;
        s_rdata = 32'h0;
        if (slv_spurious && (m_ce || (|done) || gnt == '0)) begin
            s_vld   = 1'b1;
            s_rdata = 32'hDEAD_BEEF;
        end
        if (slv_active) begin
            if (slv_cnt == slv_delay) begin
                s_vld      = 1'b1;
                s_rdata    = slv_addr ^ slv_xor;
                slv_active = 1'b0;
            end else begin
                slv_cnt++;
            end
        end
        if (m_ce) begin
            slv_active = 1'b1;
            slv_cnt    = 0;
            slv_addr   = m_addr_wdata;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        logic [NREQ-1:0] oh;
        if (!rst) begin
            sb.delete();
            in_wait   = 1'b0;
            have_done = 1'b0;
            mdl_rdata = 32'h0;
        end else if (m_ce) begin
            if (sb.size() == 0) begin
                check("cmd_unexpected", 32'(gnt), 32'd0);
            end else begin
                cur = sb[0];
                oh = '0;
                oh[cur.owner] = 1'b1;
                check("cmd_gnt", 32'(gnt), 32'(oh));
                check("cmd_wr", 32'(m_wr), 32'(cur.wr));
                check("cmd_addr", m_addr_wdata, cur.addr);
                cmd_cyc = cyc;
                in_wait = 1'b1;
            end
        end else if (|done) begin
            in_wait = 1'b0;
            if (sb.size() == 0) begin
                check("done_unexpected", 32'(done), 32'd0);
            end else begin
                cur = sb.pop_front();
                oh = '0;
                oh[cur.owner] = 1'b1;
                check("done_vec", 32'(done), 32'(oh));
                check("done_gnt", 32'(gnt), 32'(oh));
                check("done_err", 32'(err), 32'(cur.err));
                check("done_lat", 32'(cyc - cmd_cyc), 32'(cur.lat));
                if (cur.gap != 0 && have_done) check("done_gap", 32'(cyc - last_done_cyc), 32'(cur.gap));
                if (!cur.wr) mdl_rdata = cur.rdata;
                check("done_rdata", rdata, mdl_rdata);
                have_done     = 1'b1;
                last_done_cyc = cyc;
            end
        end else if (in_wait) begin
            check("wait_wr", 32'(m_wr), 32'(cur.wr));
            check("wait_bus", m_addr_wdata, cur.wr ? cur.wdata : 32'h0);
            check("wait_err", 32'(err), 32'd0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mce", 32'(m_ce), 32'd0);
        check("rst_mwr", 32'(m_wr), 32'd1);
        check("rst_bus", m_addr_wdata, 32'd0);
        rst = 1'b1;
        tick();

        // Write on requester 0, s_vld in the first data cycle.
        slv_delay = 0;
        issue(0, 1'b1, 32'h1C, 32'hF7, 32'h0, 1'b0, 2);
        tick();
        check("w_t1_mce", 32'(m_ce), 32'd1);
        check("w_t1_mwr", 32'(m_wr), 32'd1);
        check("w_t1_bus", m_addr_wdata, 32'h1C);
        check("w_t1_gnt", 32'(gnt), 32'h1);
        req_wdata[31:0] = 32'h55;
        tick();
        check("w_t2_mce", 32'(m_ce), 32'd0);
        check("w_t2_bus", m_addr_wdata, 32'hF7);
        check("w_t2_done", 32'(done), 32'd0);
        tick();
        check("w_t3_done", 32'(done), 32'h1);
        req[0] = 1'b0;
        tick();
        check("w_t4_gnt", 32'(gnt), 32'd0);
        check("w_t4_done", 32'(done), 32'd0);

        // Read on requester 2; stray s_vld in IDLE/CMD/DONE; owner drops req early.
        slv_spurious = 1'b1;
        slv_delay    = 2;
        slv_xor      = 32'h08 ^ 32'hF2;
        issue(2, 1'b0, 32'h08, 32'h0, 32'hF2, 1'b0, 4);
        tick();
        check("r_t1_mce", 32'(m_ce), 32'd1);
        check("r_t1_mwr", 32'(m_wr), 32'd0);
        check("r_t1_gnt", 32'(gnt), 32'h4);
        tick();
        req[2] = 1'b0;
        req_addr[64 +: 32] = 32'hFFFF_FFFF;
        check("r_t2_bus", m_addr_wdata, 32'd0);
        tick();
        check("r_t3_done", 32'(done), 32'd0);
        tick();
        check("r_t4_done", 32'(done), 32'd0);
        tick();
        check("r_t5_done", 32'(done), 32'h4);
        check("r_t5_rdata", rdata, 32'hF2);
        tick();
        check("r_t6_rdata", rdata, 32'hF2);
        check("r_t6_gnt", 32'(gnt), 32'd0);
        slv_spurious = 1'b0;
        tick();

        // Reset while in RWAIT: ptr was 3, so the scan wraps to requester 1.
        slv_delay = 1000;
        issue(1, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0, 0);
        tick();
        check("x_gnt", 32'(gnt), 32'h2);
        tick();
        tick();
        rst = 1'b0;
        req = '0;
        tick();
        check("x_gnt0", 32'(gnt), 32'd0);
        check("x_done0", 32'(done), 32'd0);
        check("x_rdata0", rdata, 32'd0);
        check("x_mce0", 32'(m_ce), 32'd0);
        check("x_mwr1", 32'(m_wr), 32'd1);
        check("x_bus0", m_addr_wdata, 32'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("x_nodone", 32'(done), 32'd0);
        end

        // All requesting: grants rotate 0,1,2,3,0 from the reset pointer, done every 4 cycles.
        slv_delay = 0;
        slv_xor   = 32'hA5A5_0000;
        for (int i = 0; i < NREQ; i++) begin
            req_wr[i]             = i[0];
            req_addr[32*i +: 32]  = 32'h100 + 32'(i * 4);
            req_wdata[32*i +: 32] = 32'hC0DE_0000 + 32'(i);
        end
        for (int j = 0; j < 5; j++) begin
            exp_t x;
            int o;
            o = j % NREQ;
            x.owner = o;
            x.wr    = o[0];
            x.addr  = 32'h100 + 32'(o * 4);
            x.wdata = 32'hC0DE_0000 + 32'(o);
            x.rdata = x.addr ^ 32'hA5A5_0000;
            x.err   = 1'b0;
            x.lat   = 2;
            x.gap   = (j == 0) ? 0 : 4;
            sb.push_back(x);
        end
        req = '1;
        drain("rot_drain", 60);
        req = '0;
        tick();
        tick();
        check("rot_idle_gnt", 32'(gnt), 32'd0);

`ifdef MSBUS_ARB_TIMEOUT_EN
        // Read with no s_vld: aborts 200 wait cycles after entering RWAIT.
        slv_delay = 1000;
        issue(1, 1'b0, 32'h44, 32'h0, 32'h0, 1'b1, 201);
        drain("tmo_drain", 300);
        req = '0;
        tick();
        tick();
        // s_vld on the expiry cycle completes normally.
        slv_delay = 199;
        slv_xor   = 32'h1234_5678;
        issue(2, 1'b0, 32'h48, 32'h0, 32'h48 ^ 32'h1234_5678, 1'b0, 201);
        drain("tmo_edge_drain", 300);
        req = '0;
        tick();
        tick();
`else
        // Without the timeout a long wait still completes.
        slv_delay = 250;
        slv_xor   = 32'h0F0F_0F0F;
        issue(3, 1'b0, 32'h4C, 32'h0, 32'h4C ^ 32'h0F0F_0F0F, 1'b0, 252);
        drain("long_drain", 400);
        req = '0;
        tick();
        tick();
`endif
        check("end_gnt", 32'(gnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
